// File: rtl/ram_secuenciador.sv
// Sequencer in front of the parametrizable RAM: manual read/write, slow-clock
// address scan and bulk clear. Board inputs are synchronized; all outputs registered.
module ram_secuenciador #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         slow_clk_i,
    input  logic         mode_i,
    input  logic         wr_btn_i,
    input  logic         clr_btn_i,
    input  logic [N-1:0] sw_addr_i,
    input  logic [M-1:0] sw_data_i,
    output logic [N-1:0] addr_o,
    output logic         rden_o,
    output logic         wren_o,
    output logic [M-1:0] dato_write_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        ST_MANUAL,
        ST_WRITE,
        ST_SCAN,
        ST_CLEAR
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic         r_wr_s1, r_wr_s2, r_wr_prev;
    logic         r_clr_s1, r_clr_s2, r_clr_prev;
    logic         r_slow_s1, r_slow_s2, r_slow_prev;
    logic         r_mode_s1, r_mode_s2;
    logic         w_wr_pulse, w_clr_pulse, w_slow_pulse;

    logic [N-1:0] r_addr, w_addr_nxt;
    logic         r_rden, w_rden_nxt;
    logic         r_wren, w_wren_nxt;
    logic [M-1:0] r_data, w_data_nxt;
    logic         r_busy, w_busy_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_s1     <= 1'b0;
            r_wr_s2     <= 1'b0;
            r_wr_prev   <= 1'b0;
            r_clr_s1    <= 1'b0;
            r_clr_s2    <= 1'b0;
            r_clr_prev  <= 1'b0;
            r_slow_s1   <= 1'b0;
            r_slow_s2   <= 1'b0;
            r_slow_prev <= 1'b0;
            r_mode_s1   <= 1'b0;
            r_mode_s2   <= 1'b0;
        end else begin
            r_wr_s1     <= wr_btn_i;
            r_wr_s2     <= r_wr_s1;
            r_wr_prev   <= r_wr_s2;
            r_clr_s1    <= clr_btn_i;
            r_clr_s2    <= r_clr_s1;
            r_clr_prev  <= r_clr_s2;
            r_slow_s1   <= slow_clk_i;
            r_slow_s2   <= r_slow_s1;
            r_slow_prev <= r_slow_s2;
            r_mode_s1   <= mode_i;
            r_mode_s2   <= r_mode_s1;
        end
    end

    assign w_wr_pulse   = r_wr_s2 & ~r_wr_prev;
    assign w_clr_pulse  = r_clr_s2 & ~r_clr_prev;
    assign w_slow_pulse = r_slow_s2 & ~r_slow_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_MANUAL;
            r_addr  <= '0;
            r_rden  <= 1'b0;
            r_wren  <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_rden  <= w_rden_nxt;
            r_wren  <= w_wren_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_MANUAL: begin
                if (w_clr_pulse)     w_state_nxt = ST_CLEAR;
                else if (w_wr_pulse) w_state_nxt = ST_WRITE;
                else if (r_mode_s2)  w_state_nxt = ST_SCAN;
            end
            ST_WRITE: w_state_nxt = ST_MANUAL;
            ST_SCAN: begin
                if (w_clr_pulse)     w_state_nxt = ST_CLEAR;
                else if (!r_mode_s2) w_state_nxt = ST_MANUAL;
            end
            ST_CLEAR: begin
                if (r_addr == '1)
                    w_state_nxt = r_mode_s2 ? ST_SCAN : ST_MANUAL;
            end
            default: w_state_nxt = ST_MANUAL;
        endcase
    end

    // Outputs are registered, so they are decoded from the upcoming state and
    // the transition taken into it (addr_o depends on where we came from).
    always_comb begin
        w_addr_nxt = r_addr;
        w_rden_nxt = 1'b1;
        w_wren_nxt = 1'b0;
        w_data_nxt = r_data;
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            ST_MANUAL: begin
                if (r_state == ST_CLEAR)     w_addr_nxt = '0;
                else if (r_state != ST_SCAN) w_addr_nxt = sw_addr_i;
            end
            ST_WRITE: begin
                w_rden_nxt = 1'b0;
                w_wren_nxt = 1'b1;
                w_addr_nxt = sw_addr_i;
                w_data_nxt = sw_data_i;
            end
            ST_SCAN: begin
                if (r_state == ST_CLEAR)
                    w_addr_nxt = '0;
                else if (r_state == ST_SCAN && w_slow_pulse)
                    w_addr_nxt = r_addr + 1'b1;
            end
            ST_CLEAR: begin
                w_rden_nxt = 1'b0;
                w_wren_nxt = 1'b1;
                w_busy_nxt = 1'b1;
                w_data_nxt = '0;
                w_addr_nxt = (r_state == ST_CLEAR) ? r_addr + 1'b1 : '0;
            end
            default: ;
        endcase
    end

    assign addr_o       = r_addr;
    assign rden_o       = r_rden;
    assign wren_o       = r_wren;
    assign dato_write_o = r_data;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_ram_secuenciador.sv
// Directed bench for ram_secuenciador with a behavioural 16x4 RAM on its outputs.
module tb_ram_secuenciador;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       slow_clk_i;
    logic       mode_i;
    logic       wr_btn_i;
    logic       clr_btn_i;
    logic [3:0] sw_addr_i;
    logic [3:0] sw_data_i;
    logic [3:0] addr_o;
    logic       rden_o;
    logic       wren_o;
    logic [3:0] dato_write_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;
    int wren_cnt = 0;
    int cnt0;
    logic [3:0] mem [16];

    ram_secuenciador #(.N(4), .M(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .slow_clk_i   (slow_clk_i),
        .mode_i       (mode_i),
        .wr_btn_i     (wr_btn_i),
        .clr_btn_i    (clr_btn_i),
        .sw_addr_i    (sw_addr_i),
        .sw_data_i    (sw_data_i),
        .addr_o       (addr_o),
        .rden_o       (rden_o),
        .wren_o       (wren_o),
        .dato_write_o (dato_write_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (wren_o === 1'b1) begin
            mem[addr_o] <= dato_write_o;
            wren_cnt    <= wren_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        sw_addr_i = a;
        sw_data_i = d;
        wr_btn_i  = 1'b1;
        repeat (4) tick();
        wr_btn_i  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic slow_edge(input logic [3:0] old_a, input logic [3:0] exp_a);
        slow_clk_i = 1'b1;
        tick();
        chk("scan_hold1", 32'(addr_o), 32'(old_a));
        tick();
        chk("scan_hold2", 32'(addr_o), 32'(old_a));
        tick();
        chk("scan_step", 32'(addr_o), 32'(exp_a));
        slow_clk_i = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [3:0] pre(input int i);
        return 4'(i % 15 + 1);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; slow_clk_i = 1'b0; mode_i = 1'b0;
        wr_btn_i = 1'b0; clr_btn_i = 1'b0; sw_addr_i = 4'h3; sw_data_i = 4'h0;

        // Reset values and first edge after release
        repeat (2) tick();
        chk("rst_addr", 32'(addr_o), 32'h0);
        chk("rst_rden", 32'(rden_o), 32'h0);
        chk("rst_wren", 32'(wren_o), 32'h0);
        chk("rst_data", 32'(dato_write_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst_i = 1'b0;
        tick();
        chk("rel_rden", 32'(rden_o), 32'h1);
        chk("rel_addr", 32'(addr_o), 32'h3);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rden", 32'(rden_o), 32'h0);
        chk("async_addr", 32'(addr_o), 32'h0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("rel2_rden", 32'(rden_o), 32'h1);

        // Manual write with button held for 5 cycles
        sw_addr_i = 4'h5; sw_data_i = 4'hA;
        tick();
        cnt0 = wren_cnt;
        wr_btn_i = 1'b1;
        tick();
        chk("wr_lat1", 32'(wren_o), 32'h0);
        tick();
        chk("wr_lat2", 32'(wren_o), 32'h0);
        tick();
        chk("wr_wren", 32'(wren_o), 32'h1);
        chk("wr_rden", 32'(rden_o), 32'h0);
        chk("wr_addr", 32'(addr_o), 32'h5);
        chk("wr_data", 32'(dato_write_o), 32'hA);
        tick();
        chk("wr_end", 32'(wren_o), 32'h0);
        chk("wr_rden_back", 32'(rden_o), 32'h1);
        tick();
        wr_btn_i = 1'b0;
        repeat (3) tick();
        chk("wr_once", 32'(wren_cnt - cnt0), 32'h1);
        chk("wr_mem5", 32'(mem[5]), 32'hA);
        chk("wr_data_hold", 32'(dato_write_o), 32'hA);

        // Scan with wrap; wr presses are ignored
        sw_addr_i = 4'hE;
        tick();
        chk("man_follow", 32'(addr_o), 32'hE);
        mode_i = 1'b1;
        repeat (4) tick();
        slow_edge(4'hE, 4'hF);
        slow_edge(4'hF, 4'h0);
        slow_edge(4'h0, 4'h1);
        cnt0 = wren_cnt;
        wr_btn_i = 1'b1;
        repeat (3) tick();
        wr_btn_i = 1'b0;
        repeat (3) tick();
        chk("scan_no_wr", 32'(wren_cnt - cnt0), 32'h0);
        chk("scan_addr_kept", 32'(addr_o), 32'h1);
        sw_addr_i = 4'h2;
        mode_i = 1'b0;
        repeat (4) tick();
        chk("back_manual", 32'(addr_o), 32'h2);

        // Preload, then clear with mode=0
        for (int i = 0; i < 16; i++) do_write(4'(i), pre(i));
        chk("preload9", 32'(mem[9]), 32'(pre(9)));
        sw_addr_i = 4'h2;
        cnt0 = wren_cnt;
        clr_btn_i = 1'b1;
        tick();
        tick();
        chk("clr_lat", 32'(busy_o), 32'h0);
        tick();
        chk("clr_busy0", 32'(busy_o), 32'h1);
        chk("clr_wren0", 32'(wren_o), 32'h1);
        chk("clr_rden0", 32'(rden_o), 32'h0);
        chk("clr_addr0", 32'(addr_o), 32'h0);
        chk("clr_data0", 32'(dato_write_o), 32'h0);
        for (int j = 1; j < 16; j++) begin
            tick();
            chk("clr_addr", 32'(addr_o), 32'(j));
            chk("clr_busy", 32'(busy_o), 32'h1);
        end
        tick();
        chk("clr_done_busy", 32'(busy_o), 32'h0);
        chk("clr_done_wren", 32'(wren_o), 32'h0);
        chk("clr_done_addr", 32'(addr_o), 32'h0);
        tick();
        chk("clr_to_manual", 32'(addr_o), 32'h2);
        chk("clr_count", 32'(wren_cnt - cnt0), 32'd16);
        for (int i = 0; i < 16; i++) chk("clr_mem", 32'(mem[i]), 32'h0);
        clr_btn_i = 1'b0;
        repeat (3) tick();

        // wr+clr together, mode rising, slow edge during clear
        do_write(4'h3, 4'h6);
        cnt0 = wren_cnt;
        sw_addr_i = 4'h3; sw_data_i = 4'hF;
        clr_btn_i = 1'b1; wr_btn_i = 1'b1; mode_i = 1'b1;
        tick();
        tick();
        tick();
        chk("sim_busy", 32'(busy_o), 32'h1);
        chk("sim_addr0", 32'(addr_o), 32'h0);
        slow_clk_i = 1'b1;
        for (int j = 1; j < 16; j++) begin
            tick();
            if (j == 4) slow_clk_i = 1'b0;
        end
        tick();
        chk("sim_done_busy", 32'(busy_o), 32'h0);
        chk("sim_done_addr", 32'(addr_o), 32'h0);
        repeat (3) tick();
        chk("sim_no_slow", 32'(addr_o), 32'h0);
        chk("sim_count", 32'(wren_cnt - cnt0), 32'd16);
        chk("sim_mem3", 32'(mem[3]), 32'h0);
        clr_btn_i = 1'b0; wr_btn_i = 1'b0;
        repeat (3) tick();
        slow_edge(4'h0, 4'h1);
        mode_i = 1'b0;
        repeat (4) tick();

        // Reset after the address 7 write of a clear
        for (int i = 0; i < 16; i++) do_write(4'(i), pre(i));
        clr_btn_i = 1'b1;
        repeat (3) tick();
        repeat (7) tick();
        chk("mid_addr7", 32'(addr_o), 32'h7);
        tick();
        rst_i = 1'b1;
        #1;
        chk("mid_busy", 32'(busy_o), 32'h0);
        chk("mid_wren", 32'(wren_o), 32'h0);
        chk("mid_addr", 32'(addr_o), 32'h0);
        tick();
        clr_btn_i = 1'b0;
        tick();
        rst_i = 1'b0;
        cnt0 = wren_cnt;
        repeat (5) tick();
        chk("mid_no_resume", 32'(wren_cnt - cnt0), 32'h0);
        chk("mid_busy_after", 32'(busy_o), 32'h0);
        for (int i = 0; i < 16; i++)
            chk("mid_mem", 32'(mem[i]), (i < 8) ? 32'h0 : 32'(pre(i)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_secuenciador.md
# ram_secuenciador

Control front-end that sits directly upstream of the parametrizable RAM and drives its address, read-enable, write-enable and write-data ports from board switches and push-buttons. The RAM's read data feeds the 7-segment display. It supports three functions: manual read/write at a switch-selected address, automatic address scanning paced by the divided slow clock, and a bulk clear that writes zero to every location. All outputs are registered; inputs from the board and the slow clock are synchronized internally.

## Interface
- N, 4, address width; RAM depth is 2^N
- M, 4, data width
- clk_i  in  1  system clock (10 MHz board clock)
- rst_i  in  1  reset, asynchronous, active-high
- slow_clk_i  in  1  divided clock from the frequency divider; sampled as data, never used as a clock
- mode_i  in  1  0 = manual, 1 = scan
- wr_btn_i  in  1  write request push-button, active-high
- clr_btn_i  in  1  clear-all push-button, active-high
- sw_addr_i  in  N  manual address switches
- sw_data_i  in  M  write data switches
- addr_o  out  N  to RAM addr_i
- rden_o  out  1  to RAM rden_i
- wren_o  out  1  to RAM wren_i
- dato_write_o  out  M  to RAM dato_write_i
- busy_o  out  1  high while a clear is in progress

## Operation
- Synchronizers: wr_btn_i, clr_btn_i, slow_clk_i and mode_i each pass through a 2-flop synchronizer (s1, s2).
- Edge detect: wr_btn_i, clr_btn_i and slow_clk_i each have a third "previous" flop. The pulse is s2 & ~prev, one cycle wide per rising edge.
- States: MANUAL, WRITE, SCAN, CLEAR. Reset state is MANUAL.
- MANUAL: rden_o=1, wren_o=0, addr_o <= sw_addr_i every cycle (switches are quasi-static; no synchronizer).
  - clr pulse -> CLEAR.
  - Otherwise wr pulse -> WRITE.
  - Otherwise synced mode=1 -> SCAN.
- WRITE: lasts exactly 1 cycle.
  - wren_o=1, rden_o=0, addr_o=sw_addr_i, dato_write_o=sw_data_i, all captured on entry.
  - Next state is MANUAL.
- SCAN: rden_o=1, wren_o=0.
  - Each slow pulse increments addr_o by 1, modulo 2^N (2^N-1 -> 0).
  - wr pulses are ignored.
  - clr pulse -> CLEAR.
  - Synced mode=0 -> MANUAL, and addr_o follows the switches from the next cycle.
  - On entry from MANUAL, addr_o keeps its current value.
- CLEAR: busy_o=1, wren_o=1, rden_o=0, dato_write_o=0.
  - addr_o steps 0,1,…,2^N-1, one address per cycle, for 2^N cycles.
  - After the write to 2^N-1: busy_o=0, addr_o=0, and the state becomes SCAN if synced mode=1, else MANUAL.
  - Button pulses, slow pulses and mode changes are ignored during CLEAR; nothing is queued.
- Priority on the same cycle: clr over wr over mode change. A slow pulse coinciding with a clr pulse is dropped.
- dato_write_o holds its last value outside WRITE/CLEAR.

## Timing
- Reset values: addr_o=0, rden_o=0, wren_o=0, dato_write_o=0, busy_o=0, state=MANUAL, all sync/edge flops=0. rden_o rises on the first clock edge after reset release.
- Button latency: a rising wr_btn_i that is stable before edge k gives s1=1 at k and s2=1 at k+1. wren_o is high from edge k+2 to edge k+3, i.e. exactly one cycle.
- Holding a button produces one action only; a new edge requires release (s2 low for at least 1 cycle).
- Slow-clock latency: a rising slow_clk_i before edge k updates addr_o at edge k+2.
- Clear duration: busy_o is high for exactly 2^N cycles. It rises on the same edge as the first wren_o (address 0) and falls on the edge after the last write.
- Reset mid-clear: all outputs return to reset values asynchronously. Locations not yet written keep their old contents, and no clear resumes after release.
- Any value of addr_o presented during WRITE/CLEAR is stable for the full cycle the RAM samples it.

## Test plan
- Reset: assert rst_i asynchronously between edges -> all outputs 0 immediately. After release, rden_o=1 one edge later and addr_o=sw_addr_i.
- Manual write, N=M=4: sw_addr=4'h5, sw_data=4'hA, pulse wr_btn_i for 5 cycles -> exactly one wren_o cycle with addr_o=5, dato_write_o=A, two edges after the first s1 capture. RAM address 5 then reads A.
- Scan wrap: mode_i=1, addr at 4'hE, three slow_clk rising edges -> addr_o sequence E, F, 0, 1, each change 2 edges after its slow edge. wr_btn pulses during scan cause no wren_o.
- Clear: preload RAM with nonzero values, pulse clr_btn_i -> busy_o high for 16 cycles, wren_o high with addr 0..15 and data 0. Afterwards every location reads 0 and the state follows mode_i.
- Simultaneous: wr and clr edges on the same cycle -> clear sequence only, no single-write cycle. A slow edge during clear does not advance addr_o after clear exits (addr_o=0).
- Reset mid-clear: rst_i asserted after the address 7 write -> addresses 0..7 read 0, addresses 8..15 keep their preload, busy_o=0.
